// File: rtl/cpu7_ifu_imem_resp.sv
// IFU instruction-side responder: issues SRAM line reads for fetch requests and
// returns the word-aligned line, fetch-address exception and uncached flag.
module cpu7_ifu_imem_resp #(
  parameter int          RAM_AW       = 12,
  parameter int          RAM_LAT      = 1,
  parameter logic [31:0] UNCACHE_BASE = 32'hA000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_valid,
  output logic [127:0]      inst_rdata,
  output logic [1:0]        inst_count,
  output logic              inst_ex,
  output logic [5:0]        inst_exccode,
  output logic              inst_uncache,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [127:0]      ram_rdata
);

  logic               misaligned;
  logic [RAM_LAT-1:0] v_q;
  logic [RAM_LAT-1:0] ex_q;
  logic [RAM_LAT-1:0] unc_q;
  logic [RAM_LAT-1:0][1:0] off_q;

  logic       l_v;
  logic       l_ex;
  logic       l_unc;
  logic [1:0] l_off;

  assign misaligned   = (inst_addr[1:0] != 2'b00);
  assign inst_addr_ok = inst_req & ~reset;
  assign ram_en       = inst_addr_ok & ~misaligned;
  assign ram_addr     = reset ? '0 : inst_addr[RAM_AW+3:4];

  // Stage 0 always takes the new request, even under cancel: that is the redirect fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_q   <= '0;
      ex_q  <= '0;
      unc_q <= '0;
      off_q <= '0;
    end else begin
      v_q[0]   <= inst_addr_ok;
      ex_q[0]  <= misaligned;
      off_q[0] <= inst_addr[3:2];
      unc_q[0] <= (inst_addr >= UNCACHE_BASE);
      for (int k = 1; k < RAM_LAT; k++) begin
        v_q[k]   <= v_q[k-1] & ~inst_cancel;
        ex_q[k]  <= ex_q[k-1];
        off_q[k] <= off_q[k-1];
        unc_q[k] <= unc_q[k-1];
      end
    end
  end

  assign l_v   = v_q[RAM_LAT-1] & ~reset;
  assign l_ex  = ex_q[RAM_LAT-1];
  assign l_unc = unc_q[RAM_LAT-1];
  assign l_off = off_q[RAM_LAT-1];

  assign inst_valid = l_v & ~inst_cancel;

  always_comb begin
    inst_rdata   = '0;
    inst_count   = 2'd0;
    inst_ex      = 1'b0;
    inst_exccode = 6'h00;
    inst_uncache = 1'b0;
    if (l_v) begin
      inst_ex      = l_ex;
      inst_exccode = l_ex ? 6'h08 : 6'h00;
      inst_uncache = l_unc;
      if (!l_ex) begin
        inst_rdata = ram_rdata >> {l_off, 5'b00000};
        inst_count = 2'd3 - l_off;
      end
    end
  end

endmodule
